// File: rtl/ipf_pkg.sv
// Shared definitions for the image processing filter: parameter-word layout,
// LCU/grid geometry, FSM encoding and the pixel address packing used by feeder and filter.
package ipf_pkg;

    localparam int LCU_EDGE   = 16;
    localparam int GRID_EDGE  = 8;
    localparam int PIX_ADDR_W = 14;

    // par_data layout: {type[1:0], band_pos[4:0], wo_class, offset[15:0]}
    localparam int PAR_W          = 24;
    localparam int PAR_OFFSET_LSB = 0;
    localparam int PAR_WO_BIT     = 16;
    localparam int PAR_BAND_LSB   = 17;
    localparam int PAR_TYPE_LSB   = 22;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  band_pos;
        logic        wo_class;
        logic [15:0] offset;
    } ipf_par_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PFETCH,
        ST_PLOAD,
        ST_STREAM,
        ST_DRAIN
    } feeder_state_t;

    function automatic logic [PIX_ADDR_W-1:0] pix_addr_pack(
        input logic [2:0] ly,
        input logic [3:0] row,
        input logic [2:0] lx,
        input logic [3:0] col
    );
        return {ly, row, lx, col};
    endfunction

    function automatic ipf_par_t par_unpack(input logic [PAR_W-1:0] raw);
        ipf_par_t p;
        p.typ      = raw[PAR_TYPE_LSB +: 2];
        p.band_pos = raw[PAR_BAND_LSB +: 5];
        p.wo_class = raw[PAR_WO_BIT];
        p.offset   = raw[PAR_OFFSET_LSB +: 16];
        return p;
    endfunction

endpackage

// File: rtl/ipf_lcu_addr_gen.sv
// Col/row/lcu_x/lcu_y counter chain walking the frame LCU by LCU, raster inside each LCU.
module ipf_lcu_addr_gen
    import ipf_pkg::*;
#(
    parameter int LCU_W = LCU_EDGE,
    parameter int GRID  = GRID_EDGE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [3:0] col,
    output logic [3:0] row,
    output logic [2:0] lcu_x,
    output logic [2:0] lcu_y,
    output logic       first,
    output logic       last
);

    logic col_wrap, row_wrap, lx_wrap, ly_wrap;

    assign col_wrap = (col == 4'(LCU_W - 1));
    assign row_wrap = (row == 4'(LCU_W - 1));
    assign lx_wrap  = (lcu_x == 3'(GRID - 1));
    assign ly_wrap  = (lcu_y == 3'(GRID - 1));

    assign first = (col == 4'd0) && (row == 4'd0);
    assign last  = col_wrap && row_wrap && lx_wrap && ly_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            lcu_x <= '0;
            lcu_y <= '0;
        end else if (advance) begin
            col <= col_wrap ? 4'd0 : col + 4'd1;
            if (col_wrap) begin
                row <= row_wrap ? 4'd0 : row + 4'd1;
                if (row_wrap) begin
                    lcu_x <= lx_wrap ? 3'd0 : lcu_x + 3'd1;
                    if (lx_wrap) begin
                        lcu_y <= ly_wrap ? 3'd0 : lcu_y + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 frame from pixel SRAM to the filter LCU by LCU, with per-LCU
// parameters prefetched from parameter SRAM and a one-entry hold register for busy.
//
// state  | meaning
// IDLE   | waiting for start
// PFETCH | read parameter entry 0
// PLOAD  | capture entry 0 into the shadow register
// STREAM | issue one pixel read per non-busy cycle
// DRAIN  | wait for in-flight/held/output pixels, then pulse done
module ipf_lcu_feeder
    import ipf_pkg::*;
#(
    parameter int LCU_W  = LCU_EDGE,
    parameter int GRID   = GRID_EDGE,
    parameter int ADDR_W = PIX_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              busy,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    output logic              par_rd,
    output logic [5:0]        par_addr,
    input  logic [PAR_W-1:0]  par_data,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        ipf_type,
    output logic [4:0]        ipf_band_pos,
    output logic              ipf_wo_class,
    output logic [15:0]       ipf_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    localparam logic [5:0] LAST_LCU = 6'(GRID * GRID - 1);

    feeder_state_t state, state_nxt;

    logic [3:0] ag_col, ag_row;
    logic [2:0] ag_lx, ag_ly;
    logic       ag_first, ag_last;
    logic [5:0] lcu_idx;

    logic       par_rd_q;
    ipf_par_t   shadow;
    ipf_par_t   par_out;

    logic       ret_valid, ret_first;
    logic [2:0] ret_lx, ret_ly;

    logic       hold_full, hold_first;
    logic [7:0] hold_data;
    ipf_par_t   hold_par;
    logic [2:0] hold_lx, hold_ly;

    logic       take_hold, ret_to_out, ret_to_hold;
    logic       out_empty, done_set;

    ipf_lcu_addr_gen #(
        .LCU_W (LCU_W),
        .GRID  (GRID)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .advance (pix_rd),
        .col     (ag_col),
        .row     (ag_row),
        .lcu_x   (ag_lx),
        .lcu_y   (ag_ly),
        .first   (ag_first),
        .last    (ag_last)
    );

    assign lcu_idx   = {ag_ly, ag_lx};
    assign pix_addr  = ADDR_W'(pix_addr_pack(ag_ly, ag_row, ag_lx, ag_col));
    assign out_empty = !ret_valid && !hold_full && !in_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_PFETCH;
            ST_PFETCH: state_nxt = ST_PLOAD;
            ST_PLOAD:  state_nxt = ST_STREAM;
            ST_STREAM: if (pix_rd && ag_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (out_empty) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // The first pixel of LCU k also prefetches the parameters of LCU k+1.
    always_comb begin
        pix_rd   = 1'b0;
        par_rd   = 1'b0;
        par_addr = 6'd0;
        done_set = 1'b0;
        case (state)
            ST_PFETCH: par_rd = 1'b1;
            ST_STREAM: begin
                pix_rd = !busy;
                if (!busy && ag_first && (lcu_idx != LAST_LCU)) begin
                    par_rd   = 1'b1;
                    par_addr = lcu_idx + 6'd1;
                end
            end
            ST_DRAIN:  done_set = out_empty;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_rd_q  <= 1'b0;
            shadow    <= '0;
            ret_valid <= 1'b0;
            ret_first <= 1'b0;
            ret_lx    <= '0;
            ret_ly    <= '0;
            done      <= 1'b0;
        end else begin
            par_rd_q  <= par_rd;
            if (par_rd_q) shadow <= par_unpack(par_data);
            ret_valid <= pix_rd;
            if (pix_rd) begin
                ret_first <= ag_first;
                ret_lx    <= ag_lx;
                ret_ly    <= ag_ly;
            end
            done <= done_set;
        end
    end

    // A held entry always leaves before newer data, so order is kept. The shadow is
    // sampled when a tagged pixel returns, before the next prefetch overwrites it.
    assign take_hold   = !busy && hold_full;
    assign ret_to_out  = !busy && !hold_full && ret_valid;
    assign ret_to_hold = ret_valid && !ret_to_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full  <= 1'b0;
            hold_first <= 1'b0;
            hold_data  <= '0;
            hold_par   <= '0;
            hold_lx    <= '0;
            hold_ly    <= '0;
        end else if (ret_to_hold) begin
            hold_full  <= 1'b1;
            hold_first <= ret_first;
            hold_data  <= pix_data;
            hold_par   <= shadow;
            hold_lx    <= ret_lx;
            hold_ly    <= ret_ly;
        end else if (take_hold) begin
            hold_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_en   <= 1'b0;
            din     <= '0;
            par_out <= '0;
            lcu_x   <= '0;
            lcu_y   <= '0;
        end else begin
            in_en <= take_hold || ret_to_out;
            if (take_hold) begin
                din <= hold_data;
                if (hold_first) begin
                    par_out <= hold_par;
                    lcu_x   <= hold_lx;
                    lcu_y   <= hold_ly;
                end
            end else if (ret_to_out) begin
                din <= pix_data;
                if (ret_first) begin
                    par_out <= shadow;
                    lcu_x   <= ret_lx;
                    lcu_y   <= ret_ly;
                end
            end
        end
    end

    assign ipf_type     = par_out.typ;
    assign ipf_band_pos = par_out.band_pos;
    assign ipf_wo_class = par_out.wo_class;
    assign ipf_offset   = par_out.offset;
    assign lcu_size     = 2'd0;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Self-checking bench for ipf_lcu_feeder: startup vector table, full frames with
// no/patterned/random back-pressure, mid-frame reset and ignored start.
module tb_ipf_lcu_feeder;

    logic        clk, reset, start, busy;
    logic        pix_rd, par_rd, in_en, ipf_wo_class, done;
    logic [13:0] pix_addr;
    logic [7:0]  pix_data, din;
    logic [5:0]  par_addr;
    logic [23:0] par_data;
    logic [1:0]  ipf_type, lcu_size;
    logic [4:0]  ipf_band_pos;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y;

    ipf_lcu_feeder dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
        .par_rd(par_rd), .par_addr(par_addr), .par_data(par_data),
        .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
        .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  pix_mem [16384];
    logic [23:0] par_mem [64];

    always @(posedge clk) begin
        if (pix_rd) pix_data <= pix_mem[pix_addr];
        if (par_rd) par_data <= par_mem[par_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] par_entry(input int k);
        return {2'(k % 4), 5'(k % 32), 1'(k % 2), 16'(16'hA5A5 ^ 16'(k))};
    endfunction

    function automatic logic [63:0] all_outs();
        return {pix_rd, pix_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
                ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    endfunction

    // Reference: the n-th presented pixel is pixel n of the LCU-raster walk.
    int          n, bad, par_bad, done_cnt, done_cyc, first_cyc, last_cyc, gap, max_gap;
    int          m_lcu, m_lx, m_ly, m_row, m_col;
    logic [29:0] cur_par, prev_par, exp_par, p255, p256;
    logic [7:0]  exp_din, p257_din;
    logic [2:0]  p257_lx;

    initial prev_par = '0;

    always @(negedge clk) begin
        cur_par = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_y, lcu_x};
        if (!reset) begin
            if (cur_par !== prev_par && !(in_en && (n % 256) == 0)) par_bad++;
            if (in_en) begin
                if (n < 16384) begin
                    m_lcu   = n / 256;
                    m_ly    = m_lcu / 8;
                    m_lx    = m_lcu % 8;
                    m_row   = (n % 256) / 16;
                    m_col   = n % 16;
                    exp_din = pix_mem[m_ly * 2048 + m_row * 128 + m_lx * 16 + m_col];
                    exp_par = {par_mem[m_lcu], 3'(m_ly), 3'(m_lx)};
                    if (din !== exp_din || cur_par !== exp_par) bad++;
                end else begin
                    bad++;
                end
                if (n == 255) p255 = cur_par;
                if (n == 256) begin
                    p256     = cur_par;
                    p257_lx  = lcu_x;
                    p257_din = din;
                end
                if (n == 0) first_cyc = cyc;
                else if (gap > max_gap) max_gap = gap;
                last_cyc = cyc;
                gap = 0;
                n++;
            end else if (n > 0) begin
                gap++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_par = cur_par;
    end

    task automatic mon_clear();
        n = 0; bad = 0; par_bad = 0; done_cnt = 0; done_cyc = 0;
        first_cyc = 0; last_cyc = 0; gap = 0; max_gap = 0;
        p255 = '0; p256 = '0; p257_din = '0; p257_lx = '0;
    endtask

    // mode 0: no busy, stray start at cycle 100; 1: 3-cycle stall + boundary toggling; 2: random
    task automatic run_frame(input int mode, input int k0, output int nbusy);
        nbusy = 0;
        for (int k = k0; k < 30000 && done_cnt == 0; k++) begin
            start = (k == 0) || (mode == 0 && k == 100);
            case (mode)
                1:       busy = (k >= 58 && k <= 60) || (k >= 250 && k < 290 && (k % 2) == 1);
                2:       busy = (n >= 10 && n < 16000) && ($urandom_range(3) == 0);
                default: busy = 1'b0;
            endcase
            if (busy) nbusy++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        busy  = 1'b0;
    endtask

    task automatic frame_checks(input string tag, input int nbusy);
        int idle_rd;
        idle_rd = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (pix_rd || par_rd) idle_rd++;
        end
        check_i({tag, "_pix_count"}, n, 16384);
        check_i({tag, "_pix_bad"}, bad, 0);
        check_i({tag, "_par_stable"}, par_bad, 0);
        check_i({tag, "_done_count"}, done_cnt, 1);
        check_i({tag, "_done_delay"}, done_cyc - last_cyc, 2);
        check_i({tag, "_in_en_gaps"}, last_cyc - first_cyc + 1 - 16384, nbusy);
        check_i({tag, "_idle_after"}, idle_rd, 0);
    endtask

    typedef struct {
        logic        start;
        logic        busy;
        logic        pix_rd;
        logic [13:0] pix_addr;
        logic        par_rd;
        logic [5:0]  par_addr;
        logic        in_en;
        logic [7:0]  din;
        logic [15:0] offset;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          nb;
        logic [63:0] act, exp;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 6'd0, 1'b0, 8'h00, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 6'd0, 1'b0, 8'h00, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 6'd0, 1'b0, 8'h00, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 14'd0, 1'b1, 6'd1, 1'b0, 8'h00, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 14'd1, 1'b0, 6'd0, 1'b0, 8'h00, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 14'd2, 1'b0, 6'd0, 1'b1, 8'h00, 16'hA5A5};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 14'd3, 1'b0, 6'd0, 1'b1, 8'h01, 16'hA5A5};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 14'd4, 1'b0, 6'd0, 1'b1, 8'h02, 16'hA5A5};

        for (int a = 0; a < 16384; a++) pix_mem[a] = 8'(a);
        for (int k = 0; k < 64; k++) par_mem[k] = par_entry(k);
        pix_data = '0;
        par_data = '0;
        start = 1'b0;
        busy  = 1'b0;
        mon_clear();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_v("reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_v("post_reset_outs", all_outs(), 64'd0);

        // Abort a frame with reset at pixel 1000
        mon_clear();
        for (int k = 0; k < 3000 && n < 1000; k++) begin
            start = (k == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_i("abort_reached", int'(n >= 1000), 1);
        check_i("abort_prefix_bad", bad, 0);
        reset = 1'b1;
        #1;
        check_v("abort_outs_zero", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_v("abort_release_outs", all_outs(), 64'd0);
        @(posedge clk); #1;

        // Frame A: restart, startup table, unstalled, stray start mid-stream
        mon_clear();
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start;
            busy  = vecs[i].busy;
            #1;
            act = 64'({pix_rd, pix_rd ? pix_addr : 14'd0, par_rd, par_rd ? par_addr : 6'd0,
                       in_en, din, ipf_offset});
            exp = 64'({vecs[i].pix_rd, vecs[i].pix_rd ? vecs[i].pix_addr : 14'd0,
                       vecs[i].par_rd, vecs[i].par_rd ? vecs[i].par_addr : 6'd0,
                       vecs[i].in_en, vecs[i].din, vecs[i].offset});
            check_v($sformatf("startup_cyc%0d", i), act, exp);
            @(posedge clk); #1;
        end
        run_frame(0, 8, nb);
        frame_checks("A", nb);
        check_i("A_px257_lcu_x", int'(p257_lx), 1);
        check_i("A_px257_din", int'(p257_din), 16);

        // Frame B: 3-cycle stall at col 7, busy toggling across the LCU0->LCU1 boundary
        for (int a = 0; a < 16384; a++) pix_mem[a] = 8'($urandom);
        mon_clear();
        run_frame(1, 0, nb);
        frame_checks("B", nb);
        check_i("B_max_gap", max_gap, 3);
        check_v("B_lcu0_last_par", 64'(p255), 64'({par_entry(0), 3'd0, 3'd0}));
        check_v("B_lcu1_first_par", 64'(p256), 64'({par_entry(1), 3'd0, 3'd1}));

        // Frame D: random back-pressure
        for (int a = 0; a < 16384; a++) pix_mem[a] = 8'($urandom);
        mon_clear();
        run_frame(2, 0, nb);
        frame_checks("D", nb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipf_lcu_feeder.md
# ipf_lcu_feeder

Upstream feeder for the image processing filter. Reads a 128×128 8-bit frame from pixel SRAM and a per-LCU filter parameter table from parameter SRAM. Streams the frame to the filter one 16×16 LCU at a time, raster order inside each LCU, LCUs in raster order over the 8×8 grid. Each LCU's filter parameters are held stable on the filter's parameter inputs for all 256 pixels of that LCU, and `busy` back-pressure is honoured without losing or reordering pixels.

## Interface

Parameters:
- `LCU_W`, 16: LCU edge in pixels; fixed, `lcu_size` driven as 2'd0.
- `GRID`, 8: LCUs per image edge.
- `ADDR_W`, 14: pixel SRAM address width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: begin one frame; sampled only in IDLE.
- `busy`, in, 1: filter back-pressure.
- `pix_rd`, out, 1: pixel SRAM read strobe.
- `pix_addr`, out, 14: {lcu_y[2:0], row[3:0], lcu_x[2:0], col[3:0]}.
- `pix_data`, in, 8: valid the cycle after `pix_rd`.
- `par_rd`, out, 1: parameter SRAM read strobe.
- `par_addr`, out, 6: {lcu_y, lcu_x}.
- `par_data`, in, 24: {type[1:0], band_pos[4:0], wo_class, offset[15:0]}; valid the cycle after `par_rd`.
- `in_en`, out, 1: `din` valid.
- `din`, out, 8: pixel.
- `ipf_type`, out, 2; `ipf_band_pos`, out, 5; `ipf_wo_class`, out, 1; `ipf_offset`, out, 16: filter parameters of the LCU currently streaming.
- `lcu_x`, out, 3; `lcu_y`, out, 3; `lcu_size`, out, 2: LCU coordinates and size code.
- `done`, out, 1: one-cycle pulse after the last pixel.

## Operation

- Reset value of every output is 0. FSM goes to IDLE and counters clear. Reset mid-frame aborts the frame; no resume.
- FSM states:
  - IDLE: wait for `start`, then go to PFETCH.
  - PFETCH: `par_rd`=1 with `par_addr`=0, then go to PLOAD.
  - PLOAD: capture `par_data` into the shadow register, then go to STREAM.
  - STREAM: issue pixel reads. After the final read (LCU (7,7), row 15, col 15) has been issued, go to DRAIN.
  - DRAIN: wait until the output register and hold register are empty, pulse `done`, then return to IDLE.
- `start` outside IDLE is ignored.
- Pixel issue: `pix_rd` = STREAM & !`busy`. Col counter increments on every issue. Row increments when col wraps 15→0. lcu_x increments when row and col both wrap. lcu_y increments when lcu_x wraps 7→0.
- Parameter prefetch: the issue of pixel (0,0) of LCU k < 63 also asserts `par_rd` for LCU k+1. `par_data` is captured into the shadow register the following cycle.
- Each issued read carries a `first` tag through the pipeline. When a tagged pixel reaches the output register, the shadow parameters and the LCU coordinates load into the parameter output registers in the same cycle. The parameter outputs are otherwise held.
- Output path (1-entry hold register):
  - Data returning in cycle t goes to `din` with `in_en`=1 at t+1 if `busy`=0 at t. Otherwise it goes to the hold register.
  - When `busy`=0 and the hold register is full, the hold entry goes to the output first. Order is preserved.
  - At most one read is in flight, because reads are gated by `busy`, so the hold register never overflows.
- `in_en`=0 on any cycle with nothing to present. `din` keeps its last value while `in_en`=0.
- `lcu_size` is constant 2'd0.

## Timing

- `start` high at edge 0: PFETCH in cycle 1, PLOAD in cycle 2, first `pix_rd` (addr 0) in cycle 3, first `in_en` in cycle 5 together with the LCU (0,0) parameters.
- Steady state with `busy`=0: 1 pixel/cycle, with no gap across LCU boundaries.
- Unstalled frame: 16384 `in_en` cycles. `done` pulses 2 cycles after the last `in_en`.
- `busy` asserted for N cycles: exactly N fewer issues; no `in_en` gaps beyond that; no pixel lost or duplicated.
- Parameter outputs change only on the cycle `in_en` presents col 0 / row 0 of a new LCU.

## Structure

- The shared package `ipf_pkg` holds:
  - the `par_data` field layout and offsets;
  - the LCU/grid constants;
  - the `pix_addr` packing function, shared with the filter's `dout_addr`.
- One sub-module, `ipf_lcu_addr_gen`: the col/row/lcu_x/lcu_y counter chain with an `advance` input, and `last` and `first` outputs.

## Test plan

- Reset, then `start` with `busy`=0 and pixel SRAM holding `addr[7:0]`:
  - first `in_en` at cycle 5 with `din`=0x00;
  - 16384 pixels, and `in_en` #257 carries `lcu_x`=1 with `din`=0x10;
  - `done` pulses once.
- Parameter table entry k = {2'd(k%4), 5'd(k%32), k[0], 16'hA5A5^k}:
  - each output LCU carries exactly its own entry;
  - the parameters are stable over all 256 pixels.
- `busy` high for 3 cycles mid-LCU (col 7):
  - the `din` sequence stays contiguous with no duplicate or skip;
  - `in_en` is low for exactly 3 cycles.
- `busy` toggling every cycle across the LCU (0,0)→(1,0) boundary: parameters switch on the pixel with col 0 / row 0 of LCU (1,0), not earlier.
- `reset` asserted at pixel 1000:
  - all outputs go to 0 immediately;
  - a new `start` restarts from address 0 with entry 0 parameters.
- `start` pulsed during STREAM: ignored, and the frame completes normally.
